// File: rtl/data_mem_responder.sv
// Memory-side responder for the data memory controller channels.
// Owns a single-ported word array, serves NUM_CHANNELS valid/ready channels
// through a round-robin arbiter (one array access per cycle), and accepts a
// host preload write that takes priority over every channel.
module data_mem_responder #(
  parameter int NUM_CHANNELS  = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = 2
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_CHANNELS-1:0]                     mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]  mem_read_address,
  output logic [NUM_CHANNELS-1:0]                     mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]     mem_read_data,
  input  logic [NUM_CHANNELS-1:0]                     mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]  mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]     mem_write_data,
  output logic [NUM_CHANNELS-1:0]                     mem_write_ready,
  input  logic                                        host_write_valid,
  input  logic [ADDRESS_WIDTH-1:0]                    host_write_address,
  input  logic [DATA_WIDTH-1:0]                       host_write_data
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUEUED,
    S_BUSY,
    S_RESP,
    S_DRAIN
  } chan_state_t;

  chan_state_t                                  state [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]                      op_write;
  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]   req_addr;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]      req_data;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]      rd_buf;
  logic [NUM_CHANNELS-1:0][3:0]                 lat_cnt;

  logic [DATA_WIDTH-1:0]                        mem [DEPTH];

  logic [NUM_CHANNELS-1:0]                      queued;
  logic [CH_W-1:0]                              rr_ptr;
  logic [CH_W-1:0]                              grant_idx;
  logic                                         grant_valid;
  int                                           cand;

  // Channels currently competing for the array.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      queued[i] = (state[i] == S_QUEUED);
    end
  end

  // Round-robin search from rr_ptr; a host write blocks every grant.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    if (!host_write_valid) begin
      for (int off = 0; off < NUM_CHANNELS; off++) begin
        cand = int'(rr_ptr) + off;
        if (cand >= NUM_CHANNELS) cand = cand - NUM_CHANNELS;
        if (!grant_valid && queued[CH_W'(cand)]) begin
          grant_valid = 1'b1;
          grant_idx   = CH_W'(cand);
        end
      end
    end
  end

  // Pointer moves past the granted channel; idle cycles leave it alone.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Array write port: host preload first, otherwise the granted channel's write.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents survive a reset pulse and it maps onto plain SRAM.
    if (host_write_valid) begin
      mem[host_write_address] <= host_write_data;
    end else if (grant_valid && op_write[grant_idx]) begin
      mem[req_addr[grant_idx]] <= req_data[grant_idx];
    end
  end

  // Per-channel request FSM with registered ready pulses and held read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state[i] <= S_IDLE;
      end
      op_write        <= '0;
      req_addr        <= '0;
      req_data        <= '0;
      rd_buf          <= '0;
      lat_cnt         <= '0;
      mem_read_ready  <= '0;
      mem_write_ready <= '0;
      mem_read_data   <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        mem_read_ready[i]  <= 1'b0;
        mem_write_ready[i] <= 1'b0;
        unique case (state[i])
          S_IDLE: begin
            // Write wins when both are requested; the read is retaken later.
            if (mem_write_valid[i]) begin
              op_write[i] <= 1'b1;
              req_addr[i] <= mem_write_address[i];
              req_data[i] <= mem_write_data[i];
              state[i]    <= S_QUEUED;
            end else if (mem_read_valid[i]) begin
              op_write[i] <= 1'b0;
              req_addr[i] <= mem_read_address[i];
              state[i]    <= S_QUEUED;
            end
          end
          S_QUEUED: begin
            if (grant_valid && (grant_idx == CH_W'(i))) begin
              if (!op_write[i]) rd_buf[i] <= mem[req_addr[i]];
              if (LATENCY == 1) begin
                state[i] <= S_RESP;
                if (op_write[i]) begin
                  mem_write_ready[i] <= 1'b1;
                end else begin
                  mem_read_ready[i] <= 1'b1;
                  mem_read_data[i]  <= mem[req_addr[i]];
                end
              end else begin
                state[i]   <= S_BUSY;
                lat_cnt[i] <= 4'(LATENCY - 1);
              end
            end
          end
          S_BUSY: begin
            // BUSY lasts LATENCY-1 cycles so ready lands LATENCY cycles after grant.
            if (lat_cnt[i] <= 4'd1) begin
              state[i] <= S_RESP;
              if (op_write[i]) begin
                mem_write_ready[i] <= 1'b1;
              end else begin
                mem_read_ready[i] <= 1'b1;
                mem_read_data[i]  <= rd_buf[i];
              end
            end else begin
              lat_cnt[i] <= lat_cnt[i] - 4'd1;
            end
          end
          S_RESP: begin
            state[i] <= S_DRAIN;
          end
          S_DRAIN: begin
            // Wait for the served op's valid to drop so one request gives one response.
            if (op_write[i] ? !mem_write_valid[i] : !mem_read_valid[i]) begin
              state[i] <= S_IDLE;
            end
          end
          default: state[i] <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus
// randomized batches checked against a grant-order / array reference model.
module tb_data_mem_responder;

  localparam int N   = 8;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          mem_read_valid;
  logic [N-1:0][AW-1:0]  mem_read_address;
  logic [N-1:0]          mem_read_ready;
  logic [N-1:0][DW-1:0]  mem_read_data;
  logic [N-1:0]          mem_write_valid;
  logic [N-1:0][AW-1:0]  mem_write_address;
  logic [N-1:0][DW-1:0]  mem_write_data;
  logic [N-1:0]          mem_write_ready;
  logic                  host_write_valid;
  logic [AW-1:0]         host_write_address;
  logic [DW-1:0]         host_write_data;

  data_mem_responder #(
    .NUM_CHANNELS (N),
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .LATENCY      (LAT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_read_valid    (mem_read_valid),
    .mem_read_address  (mem_read_address),
    .mem_read_ready    (mem_read_ready),
    .mem_read_data     (mem_read_data),
    .mem_write_valid   (mem_write_valid),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_ready   (mem_write_ready),
    .host_write_valid  (host_write_valid),
    .host_write_address(host_write_address),
    .host_write_data   (host_write_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: array contents and round-robin pointer.
  logic [DW-1:0] m_mem [256];
  int            m_ptr;

  // Batch description and expectations.
  bit            b_en   [N];
  bit            b_wr   [N];
  logic [AW-1:0] b_addr [N];
  logic [DW-1:0] b_data [N];
  int            exp_cyc[N];
  logic [DW-1:0] exp_dat[N];

  // Observed pulses.
  int            rd_cnt [N];
  int            wr_cnt [N];
  int            rd_cyc [N];
  int            wr_cyc [N];
  logic [DW-1:0] rd_dat [N];

  int checks = 0;
  int errors = 0;
  int batch_id = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < N; i++) begin
      rd_cnt[i] = 0; wr_cnt[i] = 0; rd_cyc[i] = -1; wr_cyc[i] = -1; rd_dat[i] = '0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (mem_read_ready[i] === 1'b1) begin
        rd_cnt[i]++; rd_cyc[i] = cyc; rd_dat[i] = mem_read_data[i];
      end
      if (mem_write_ready[i] === 1'b1) begin
        wr_cnt[i]++; wr_cyc[i] = cyc;
      end
    end
  endtask

  task automatic clear_batch();
    for (int i = 0; i < N; i++) begin
      b_en[i] = 1'b0; b_wr[i] = 1'b0; b_addr[i] = '0; b_data[i] = '0;
    end
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_write_valid   = 1'b1;
    host_write_address = a;
    host_write_data    = d;
    m_mem[a]           = d;
    tick();
    host_write_valid   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_ptr = 0;
    tick();
    reset = 1'b1;
  endtask

  // Launch every enabled channel in the same cycle; optional host stall in cycles 1..stall.
  task automatic do_batch(input int stall, input logic [AW-1:0] haddr, input logic [DW-1:0] hdata);
    int k, last, win, idx, t0;
    clear_mon();
    t0 = cyc;
    if (stall > 0) m_mem[haddr] = hdata;
    k = 0; last = -1;
    for (int off = 0; off < N; off++) begin
      idx = (m_ptr + off) % N;
      if (b_en[idx]) begin
        exp_cyc[idx] = t0 + 1 + stall + k + LAT;
        if (b_wr[idx]) m_mem[b_addr[idx]] = b_data[idx];
        else           exp_dat[idx] = m_mem[b_addr[idx]];
        k++;
        last = idx;
      end
    end
    if (last >= 0) m_ptr = (last + 1) % N;
    for (int i = 0; i < N; i++) begin
      mem_read_valid[i]    = b_en[i] && !b_wr[i];
      mem_write_valid[i]   = b_en[i] && b_wr[i];
      mem_read_address[i]  = b_addr[i];
      mem_write_address[i] = b_addr[i];
      mem_write_data[i]    = b_data[i];
    end
    host_write_address = haddr;
    host_write_data    = hdata;
    win = 2 + stall + k + LAT;
    for (int t = 0; t < win; t++) begin
      host_write_valid = (t >= 1) && (t <= stall);
      sample();
      tick();
    end
    host_write_valid = 1'b0;
    mem_read_valid   = '0;
    mem_write_valid  = '0;
    for (int t = 0; t < 4; t++) begin
      sample();
      tick();
    end
    for (int i = 0; i < N; i++) begin
      if (!b_en[i]) begin
        check($sformatf("b%0d ch%0d idle pulses", batch_id, i), rd_cnt[i] + wr_cnt[i], 0);
      end else if (b_wr[i]) begin
        check($sformatf("b%0d ch%0d wr_cnt", batch_id, i), wr_cnt[i], 1);
        check($sformatf("b%0d ch%0d wr_cyc", batch_id, i), wr_cyc[i] - t0, exp_cyc[i] - t0);
        check($sformatf("b%0d ch%0d rd_cnt on write", batch_id, i), rd_cnt[i], 0);
      end else begin
        check($sformatf("b%0d ch%0d rd_cnt", batch_id, i), rd_cnt[i], 1);
        check($sformatf("b%0d ch%0d rd_cyc", batch_id, i), rd_cyc[i] - t0, exp_cyc[i] - t0);
        check($sformatf("b%0d ch%0d rd_dat", batch_id, i), rd_dat[i], exp_dat[i]);
        check($sformatf("b%0d ch%0d rd_hold", batch_id, i), mem_read_data[i], exp_dat[i]);
        check($sformatf("b%0d ch%0d wr_cnt on read", batch_id, i), wr_cnt[i], 0);
      end
    end
    batch_id++;
  endtask

  initial begin
    int t0, rel;
    logic [DW-1:0] wval;

    reset              = 1'b0;
    mem_read_valid     = '0;
    mem_read_address   = '0;
    mem_write_valid    = '0;
    mem_write_address  = '0;
    mem_write_data     = '0;
    host_write_valid   = 1'b0;
    host_write_address = '0;
    host_write_data    = '0;
    m_ptr              = 0;
    clear_batch();
    repeat (2) @(posedge clk);
    #1;
    check("reset read_ready", mem_read_ready, 0);
    check("reset write_ready", mem_write_ready, 0);
    check("reset read_data", |mem_read_data, 0);
    reset = 1'b1;
    tick();

    // Fill the whole array so every later read has a known value.
    for (int a = 0; a < 256; a++) host_write(AW'(a), $urandom);

    // Single read after preload.
    do_reset();
    host_write(8'h10, 32'hDEADBEEF);
    clear_batch();
    b_en[0] = 1'b1; b_addr[0] = 8'h10;
    do_batch(0, '0, '0);

    // All channels read at once: grants in channel order from pointer 0.
    do_reset();
    for (int i = 0; i < N; i++) host_write(AW'(i), 32'h100 + i);
    clear_batch();
    for (int i = 0; i < N; i++) begin b_en[i] = 1'b1; b_addr[i] = AW'(i); end
    do_batch(0, '0, '0);

    // Write on ch2 then read on ch5 of the same address.
    do_reset();
    clear_batch();
    b_en[2] = 1'b1; b_wr[2] = 1'b1; b_addr[2] = 8'h20; b_data[2] = 32'hCAFE0001;
    b_en[5] = 1'b1; b_addr[5] = 8'h20;
    do_batch(0, '0, '0);

    // Host write held for three cycles stalls all grants.
    do_reset();
    clear_batch();
    b_en[0] = 1'b1; b_addr[0] = 8'h10;
    b_en[1] = 1'b1; b_addr[1] = 8'h11;
    do_batch(3, 8'h50, 32'h5A5A_0050);

    // Pointer fairness: after ch7 is served, ch0 goes before ch7.
    do_reset();
    clear_batch();
    b_en[7] = 1'b1; b_addr[7] = 8'h07;
    do_batch(0, '0, '0);
    clear_batch();
    b_en[0] = 1'b1; b_addr[0] = 8'h00;
    b_en[7] = 1'b1; b_addr[7] = 8'h07;
    do_batch(0, '0, '0);
    check("fairness ch0 before ch7", rd_cyc[0] < rd_cyc[7], 1);

    // Randomized batches over a small address window to create hazards.
    for (int b = 0; b < 24; b++) begin
      bit any;
      clear_batch();
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        b_en[i]   = 1'($urandom_range(0, 1));
        b_wr[i]   = 1'($urandom_range(0, 1));
        b_addr[i] = AW'(8'h40 + $urandom_range(0, 3));
        b_data[i] = $urandom;
        any       = any | b_en[i];
      end
      if (!any) b_en[$urandom_range(0, N - 1)] = 1'b1;
      do_batch($urandom_range(0, 2), AW'(8'h40 + $urandom_range(0, 3)), $urandom);
    end

    // Reset while ch3's read is in BUSY: response dropped, fresh one after release.
    clear_mon();
    mem_read_valid[3]   = 1'b1;
    mem_read_address[3] = 8'h10;
    t0 = cyc;
    sample(); tick();
    sample(); tick();
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("midreset read_ready", mem_read_ready, 0);
    check("midreset write_ready", mem_write_ready, 0);
    check("midreset read_data", |mem_read_data, 0);
    #1 reset = 1'b1;
    m_ptr = 4;
    rel = cyc;
    check("release in busy cycle", rel - t0, 2);
    for (int t = 0; t < LAT + 5; t++) begin
      tick();
      sample();
    end
    check("post-reset ch3 rd_cnt", rd_cnt[3], 1);
    check("post-reset ch3 rd_cyc", rd_cyc[3] - rel, 1 + LAT);
    check("post-reset ch3 rd_dat", rd_dat[3], m_mem[8'h10]);
    tick();
    mem_read_valid = '0;
    repeat (3) tick();

    // Reset after a write is granted: the write stays in the array.
    wval = 32'h0BAD_F00D;
    clear_mon();
    mem_write_valid[4]   = 1'b1;
    mem_write_address[4] = 8'h30;
    mem_write_data[4]    = wval;
    tick(); tick();
    @(negedge clk);
    #1 reset = 1'b0;
    mem_write_valid = '0;
    #1 reset = 1'b1;
    m_mem[8'h30] = wval;
    m_ptr = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      sample();
    end
    check("dropped write response", wr_cnt[4], 0);
    tick();
    clear_batch();
    b_en[0] = 1'b1; b_addr[0] = 8'h30;
    do_batch(0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the data memory controller's channel interface. It owns the data memory array and serves up to NUM_CHANNELS concurrent channels using a per-channel valid/ready handshake. The array is single-ported, so a round-robin arbiter grants one access per cycle. A host preload port feeds the array for bring-up and testbenches. It sits between the GPU top-level data_mem_* ports and the SRAM, or serves as the simulation memory model.

Parameters:
NUM_CHANNELS, 8, number of controller channels served
ADDRESS_WIDTH, 8, word address width; array depth 2**ADDRESS_WIDTH
DATA_WIDTH, 32, word width
LATENCY, 2, cycles from grant to ready pulse (legal range 1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
mem_read_valid  in  NUM_CHANNELS  per-channel read request
mem_read_address  in  NUM_CHANNELS x ADDRESS_WIDTH  read word address
mem_read_ready  out  NUM_CHANNELS  one-cycle read completion pulse
mem_read_data  out  NUM_CHANNELS x DATA_WIDTH  read data, valid with ready, held afterwards
mem_write_valid  in  NUM_CHANNELS  per-channel write request
mem_write_address  in  NUM_CHANNELS x ADDRESS_WIDTH  write word address
mem_write_data  in  NUM_CHANNELS x DATA_WIDTH  write data
mem_write_ready  out  NUM_CHANNELS  one-cycle write completion pulse
host_write_valid  in  1  preload write, highest priority
host_write_address  in  ADDRESS_WIDTH  preload address
host_write_data  in  DATA_WIDTH  preload data

Behaviour:
- Reset (reset low, asynchronous):
  - all channel FSMs go to IDLE; all ready outputs 0; all mem_read_data 0; arbiter pointer 0.
  - Array contents are NOT cleared.
- Per-channel FSM: IDLE -> QUEUED -> BUSY -> RESP -> DRAIN -> IDLE.
  - IDLE: a request sampled high moves the channel to QUEUED. Op, address and write data are latched at this edge; later input changes are ignored. If read and write valid are both high, the write is served first. The read is taken as a new request after return to IDLE if it is still high.
  - QUEUED: the channel competes for the array. On grant it performs the array access at that edge and moves to BUSY with counter = LATENCY-1.
  - BUSY: counts down. At 0 it moves to RESP; LATENCY=1 goes straight to RESP.
  - RESP: the matching ready is high for exactly one cycle. Read data is driven in the same cycle and held until the next read completes on that channel.
  - DRAIN: waits until the served op's valid is sampled low, then goes to IDLE. A valid held high after ready never produces a second response.
- Timing: uncontended request with valid high in cycle 0 -> granted cycle 1 -> ready in cycle 1+LATENCY.
- Arbiter:
  - Exactly one array access per cycle.
  - Search starts at the pointer over QUEUED channels. After granting channel k, pointer = (k+1) mod NUM_CHANNELS.
  - No grant leaves the pointer unchanged.
- host_write_valid high: the array is written that cycle, no channel is granted, and the pointer is unchanged.
- Ordering: array accesses occur in grant order. A read granted after a write to the same address returns the new data.
- Addresses wrap naturally within ADDRESS_WIDTH; there is no out-of-range detection.
- Reset during BUSY/RESP/DRAIN:
  - the pending response is dropped; any write already granted remains in the array.
  - after reset deasserts, a still-high valid is treated as a new request.

Test Plan:
- Preload addr 0x10=0xDEADBEEF via host port. Ch0 read 0x10 in cycle 0 (LATENCY=2) -> mem_read_ready[0] high only in cycle 3, data 0xDEADBEEF. Valid held through cycle 4 then dropped -> no second pulse.
- Preload addr i=0x100+i. All 8 channels read addr i in cycle 0 -> grants cycles 1..8, ready[i] in cycle 3+i, each returns 0x100+i.
- Ch2 writes 0xCAFE0001 to 0x20 and ch5 reads 0x20, both cycle 0 -> ch2 granted first; write_ready[2] cycle 3; ch5 read_ready cycle 4 with 0xCAFE0001.
- Host write held high cycles 1-3 while ch0 and ch1 read from cycle 0 -> no grants cycles 1-3; ch0 granted cycle 4 (ready cycle 6), ch1 granted cycle 5 (ready cycle 7).
- Pointer fairness: ch7 served, then ch0 and ch7 re-request together -> ch0 granted before ch7.
- Ch3 read in BUSY, reset pulsed low mid-cycle -> all readies and data 0 immediately. Valid still high after release -> fresh response at LATENCY+1 cycles; array contents unchanged.
